// File: rtl/axi_chk_pkg.sv
// rtl/axi_chk_pkg.sv - shared error indices, queue entry type and response codes for the AXI checker
package axi_chk_pkg;

  localparam int ERR_W = 12;

  localparam int ERR_AW_STABLE = 0;
  localparam int ERR_W_STABLE  = 1;
  localparam int ERR_AR_STABLE = 2;
  localparam int ERR_B_STABLE  = 3;
  localparam int ERR_R_STABLE  = 4;
  localparam int ERR_TIMEOUT   = 5;
  localparam int ERR_WLAST     = 6;
  localparam int ERR_RLAST     = 7;
  localparam int ERR_B_UNEXP   = 8;
  localparam int ERR_R_UNEXP   = 9;
  localparam int ERR_EXOKAY    = 10;
  localparam int ERR_OVERFLOW  = 11;

  // IDs are stored zero-extended to a fixed width so the entry type is parameter-free
  localparam int Q_ID_W = 32;

  typedef struct packed {
    logic [Q_ID_W-1:0] id;
    logic [7:0]        len;
    logic              lock;
  } q_entry_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Index of the lowest set bit; 0 when nothing is set
  function automatic logic [3:0] lowest_err(input logic [ERR_W-1:0] v);
    lowest_err = '0;
    for (int i = ERR_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_err = 4'(i);
    end
  endfunction

endpackage

// File: rtl/axi_chk_fifo.sv
// rtl/axi_chk_fifo.sv - tracking queue whose head shows a same-cycle push when empty
module axi_chk_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          store;
  logic          drain;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_data = empty ? push_data : mem[rd_ptr];

  // A pop of an empty queue consumes the bypassed push, so nothing is stored.
  // A full queue still accepts a push when a stored entry leaves the same cycle.
  assign drain = pop & ~empty;
  assign store = push & ~(empty & pop) & (~full | pop);

  // Pointer and occupancy update; storage itself needs no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (drain) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(store) - CW'(drain);
    end
  end

endmodule

// File: rtl/axi_protocol_checker.sv
// rtl/axi_protocol_checker.sv - passive AXI4 slave-side protocol checker; AXI_CHECKER_STATS_EN adds traffic/error counters
module axi_protocol_checker
  import axi_chk_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 16,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axi_awvalid,
  input  logic                  s_axi_awready,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic                  s_axi_wvalid,
  input  logic                  s_axi_wready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_bid,
  input  logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_arvalid,
  input  logic                  s_axi_arready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [ID_WIDTH-1:0]   s_axi_rid,
  input  logic [DATA_WIDTH-1:0] s_axi_rdata,
  input  logic [1:0]            s_axi_rresp,
  input  logic                  s_axi_rlast,
  input  logic                  err_clr,
  output logic [ERR_W-1:0]      err_vec,
  output logic                  err_pulse,
  output logic [3:0]            err_code
`ifdef AXI_CHECKER_STATS_EN
  ,
  output logic [31:0]           wr_cnt,
  output logic [31:0]           rd_cnt,
  output logic [15:0]           err_cnt
`endif
);

  localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BW  = Q_ID_W + 1;
  localparam int TW  = $clog2(TIMEOUT + 2);
  localparam int AXP = ID_WIDTH + ADDR_WIDTH + 14;
  localparam int WP  = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int BP  = ID_WIDTH + 2;
  localparam int RP  = ID_WIDTH + DATA_WIDTH + 3;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign b_hs  = s_axi_bvalid  & s_axi_bready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_hs  = s_axi_rvalid  & s_axi_rready;

  // ---------------- write address / data / response tracking ----------------
  q_entry_t          aw_in, aw_head;
  logic              aw_full, aw_empty, aw_pop;
  logic [CW-1:0]     aw_count;
  logic [BW-1:0]     b_in, b_head;
  logic              b_full, b_empty, b_pop;
  logic [CW-1:0]     b_count;
  logic [8:0]        w_cnt, w_beat, w_target;
  logic              w_avail, w_done, b_match;

  assign aw_in = '{id: Q_ID_W'(s_axi_awid), len: s_axi_awlen, lock: s_axi_awlock};

  axi_chk_fifo #(.W($bits(q_entry_t)), .DEPTH(MAX_OUTSTANDING)) u_aw_q (
    .clk(clk), .rst(rst), .push(aw_hs), .push_data(aw_in), .pop(aw_pop),
    .head_data(aw_head), .full(aw_full), .empty(aw_empty), .count(aw_count)
  );

  // W sees an AW accepted in the same cycle through the queue bypass
  assign w_avail  = ~aw_empty | aw_hs;
  assign w_beat   = w_cnt + 9'd1;
  assign w_target = {1'b0, aw_head.len} + 9'd1;
  assign w_done   = w_hs & w_avail & (w_beat == w_target);
  assign aw_pop   = w_done;

  assign b_in  = {aw_head.id, aw_head.lock};
  assign b_pop = b_hs & ~b_empty;

  axi_chk_fifo #(.W(BW), .DEPTH(MAX_OUTSTANDING)) u_b_q (
    .clk(clk), .rst(rst), .push(w_done), .push_data(b_in), .pop(b_pop),
    .head_data(b_head), .full(b_full), .empty(b_empty), .count(b_count)
  );

  assign b_match = ~b_empty & (b_head[BW-1:1] == Q_ID_W'(s_axi_bid));

  // ---------------- read address / data tracking ----------------
  q_entry_t          ar_in, ar_head;
  logic              ar_full, ar_empty, ar_pop;
  logic [CW-1:0]     ar_count;
  logic [8:0]        r_cnt, r_beat, r_target;
  logic              r_avail, r_done;

  assign ar_in = '{id: Q_ID_W'(s_axi_arid), len: s_axi_arlen, lock: s_axi_arlock};

  axi_chk_fifo #(.W($bits(q_entry_t)), .DEPTH(MAX_OUTSTANDING)) u_ar_q (
    .clk(clk), .rst(rst), .push(ar_hs), .push_data(ar_in), .pop(ar_pop),
    .head_data(ar_head), .full(ar_full), .empty(ar_empty), .count(ar_count)
  );

  assign r_avail  = ~ar_empty;
  assign r_beat   = r_cnt + 9'd1;
  assign r_target = {1'b0, ar_head.len} + 9'd1;
  assign r_done   = r_hs & r_avail & (r_beat == r_target);
  assign ar_pop   = r_done;

  // Occupancy counts are observable on the queues but not needed for any check
  logic unused_q_count;
  assign unused_q_count = ^{aw_count, b_count, ar_count};

  // Beat counters for the burst at the head of each address queue
  always_ff @(posedge clk) begin
    if (rst) begin
      w_cnt <= '0;
      r_cnt <= '0;
    end else begin
      if (w_hs & w_avail) w_cnt <= w_done ? 9'd0 : w_beat;
      if (r_hs & r_avail) r_cnt <= r_done ? 9'd0 : r_beat;
    end
  end

  // ---------------- stability and timeout ----------------
  // Channel order in these vectors follows the STABLE error bits: AW, W, AR, B, R
  logic [4:0]     vld, rdy, chg, stall_q, t_hit;
  logic [AXP-1:0] aw_pl, aw_pl_q, ar_pl, ar_pl_q;
  logic [WP-1:0]  w_pl, w_pl_q;
  logic [BP-1:0]  b_pl, b_pl_q;
  logic [RP-1:0]  r_pl, r_pl_q;
  logic [TW-1:0]  t_cnt [5];

  assign vld = {s_axi_rvalid, s_axi_bvalid, s_axi_arvalid, s_axi_wvalid, s_axi_awvalid};
  assign rdy = {s_axi_rready, s_axi_bready, s_axi_arready, s_axi_wready, s_axi_awready};

  assign aw_pl = {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock};
  assign ar_pl = {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock};
  assign w_pl  = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
  assign b_pl  = {s_axi_bid, s_axi_bresp};
  assign r_pl  = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};

  assign chg = {r_pl != r_pl_q, b_pl != b_pl_q, ar_pl != ar_pl_q, w_pl != w_pl_q, aw_pl != aw_pl_q};

  // Payload history; only consulted when stall_q says the previous cycle stalled
  always_ff @(posedge clk) begin
    aw_pl_q <= aw_pl;
    w_pl_q  <= w_pl;
    ar_pl_q <= ar_pl;
    b_pl_q  <= b_pl;
    r_pl_q  <= r_pl;
  end

  // Stall history and per-channel wait counters, saturating so a stall times out once
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      for (int i = 0; i < 5; i++) t_cnt[i] <= '0;
    end else begin
      stall_q <= vld & ~rdy;
      for (int i = 0; i < 5; i++) begin
        if (!vld[i] || rdy[i])             t_cnt[i] <= '0;
        else if (t_cnt[i] != TW'(TIMEOUT)) t_cnt[i] <= t_cnt[i] + TW'(1);
      end
    end
  end

  // A stalled channel whose counter is one short of the limit times out this cycle
  always_comb begin
    t_hit = '0;
    for (int i = 0; i < 5; i++) begin
      t_hit[i] = (TIMEOUT != 0) && vld[i] && !rdy[i] && (t_cnt[i] == TW'(TIMEOUT - 1));
    end
  end

  // ---------------- error detection and reporting ----------------
  logic [ERR_W-1:0] det;

  // Combine every check into this cycle's new-error vector
  always_comb begin
    det = '0;
    det[ERR_AW_STABLE] = stall_q[0] & (~vld[0] | chg[0]);
    det[ERR_W_STABLE]  = stall_q[1] & (~vld[1] | chg[1]);
    det[ERR_AR_STABLE] = stall_q[2] & (~vld[2] | chg[2]);
    det[ERR_B_STABLE]  = stall_q[3] & (~vld[3] | chg[3]);
    det[ERR_R_STABLE]  = stall_q[4] & (~vld[4] | chg[4]);
    det[ERR_TIMEOUT]   = |t_hit;
    det[ERR_WLAST]     = w_hs & w_avail & (s_axi_wlast != (w_beat == w_target));
    det[ERR_RLAST]     = r_hs & r_avail & (s_axi_rlast != (r_beat == r_target));
    det[ERR_B_UNEXP]   = (w_hs & ~w_avail) | (b_hs & ~b_match);
    det[ERR_R_UNEXP]   = r_hs & (~r_avail | (ar_head.id != Q_ID_W'(s_axi_rid)));
    det[ERR_EXOKAY]    = (b_hs & ~b_empty & (s_axi_bresp == RESP_EXOKAY) & ~b_head[0])
                       | (r_hs & r_avail & (s_axi_rresp == RESP_EXOKAY) & ~ar_head.lock);
    det[ERR_OVERFLOW]  = (aw_hs & aw_full & ~aw_pop)
                       | (w_done & b_full & ~b_pop)
                       | (ar_hs & ar_full & ~ar_pop);
  end

  // Sticky vector (a new error beats a simultaneous clear), pulse and held code
  always_ff @(posedge clk) begin
    if (rst) begin
      err_vec   <= '0;
      err_pulse <= 1'b0;
      err_code  <= '0;
    end else begin
      err_vec   <= (err_clr ? '0 : err_vec) | det;
      err_pulse <= |det;
      if (|det) err_code <= lowest_err(det);
    end
  end

`ifdef AXI_CHECKER_STATS_EN
  // Completed write/read transactions and error-pulse cycles since the last clear
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (b_hs)                             wr_cnt  <= wr_cnt + 32'd1;
      if (r_hs && s_axi_rlast)              rd_cnt  <= rd_cnt + 32'd1;
      if (err_pulse && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
